// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM arbiter: scanout read bursts take priority, a pixel writer fills idle cycles.
// Define FB_ARB_STATS_EN to build the writer stall counter; otherwise o_wr_stall_cnt is tied to 0.
module fb_port_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12,
  parameter int BURST_LEN = 16
) (
  input  logic              clk_100m,
  input  logic              reset,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_busy,
  output logic              o_rd_overrun,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [15:0]       o_wr_stall_cnt
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_pendAddr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pendValid;
  logic              r_overrun;
  logic              r_rdValid;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdHold;

  logic              w_lastBeat;
  logic              w_wrReady;
  logic [ADDR_W-1:0] w_readAddr;

  assign w_lastBeat = (r_cnt == LAST_BEAT);
  assign w_readAddr = r_base + ADDR_W'(r_cnt);
  assign w_wrReady  = (r_state == IDLE) && !i_rd_req;

  // On the last beat a queued request (pending first, else a same-cycle rd_req) chains with no gap.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pendValid <= 1'b0;
      r_overrun   <= 1'b0;
      r_rdValid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdValid <= (r_state == READ);
      case (r_state)
        IDLE: begin
          if (i_rd_req) begin
            r_state <= READ;
            r_busy  <= 1'b1;
            r_base  <= i_rd_addr;
            r_cnt   <= '0;
          end
        end
        READ: begin
          if (!w_lastBeat) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_rd_req) begin
              if (!r_pendValid) begin
                r_pendValid <= 1'b1;
                r_pendAddr  <= i_rd_addr;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end else if (r_pendValid) begin
            r_base      <= r_pendAddr;
            r_cnt       <= '0;
            r_pendValid <= i_rd_req;
            if (i_rd_req) begin
              r_pendAddr <= i_rd_addr;
            end
          end else if (i_rd_req) begin
            r_base <= i_rd_addr;
            r_cnt  <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Keeps the last returned word so rd_data holds steady between bursts.
  always_ff @(posedge clk_100m) begin
    if (r_rdValid) begin
      r_rdHold <= i_mem_rdata;
    end
  end

  assign o_rd_valid   = r_rdValid;
  assign o_rd_data    = r_rdValid ? i_mem_rdata : r_rdHold;
  assign o_rd_busy    = r_busy;
  assign o_rd_overrun = r_overrun;
  assign o_wr_ready   = w_wrReady;
  assign o_mem_we     = w_wrReady && i_wr_valid;
  assign o_mem_addr   = (r_state == READ) ? w_readAddr : i_wr_addr;
  assign o_mem_wdata  = i_wr_data;

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stallCnt;

  always_ff @(posedge clk_100m) begin
    if (reset) begin
      r_stallCnt <= '0;
    end else if (i_wr_valid && !w_wrReady && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign o_wr_stall_cnt = r_stallCnt;
`else
  assign o_wr_stall_cnt = 16'd0;
`endif

endmodule
